// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan bus: glyph table, nibble codes,
// receiver FSM states and the sampled-bus record.
package fnd_pkg;

  localparam int N_DIG = 6;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] NIB_BLANK = 4'hA;
  localparam logic [3:0] NIB_BAD   = 4'hF;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_HELD = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [N_DIG-1:0] enb;
    logic [6:0]       seg;
    logic             dp;
  } smp_t;

  // Idle bus: every enable high, nothing lit.
  localparam smp_t SMP_IDLE = '{enb: {N_DIG{1'b1}}, seg: SEG_BLANK, dp: 1'b0};

endpackage

// File: rtl/fnd_seg_dec.sv
// Inverse 7-segment decoder: glyph -> BCD nibble, flags glyphs outside the table.
module fnd_seg_dec
  import fnd_pkg::*;
(
  input  logic [6:0] i_glyph,
  output logic [3:0] o_nib,
  output logic       o_bad
);

  always_comb begin
    o_nib = NIB_BAD;
    o_bad = 1'b0;
    case (i_glyph)
      SEG_0:     o_nib = 4'h0;
      SEG_1:     o_nib = 4'h1;
      SEG_2:     o_nib = 4'h2;
      SEG_3:     o_nib = 4'h3;
      SEG_4:     o_nib = 4'h4;
      SEG_5:     o_nib = 4'h5;
      SEG_6:     o_nib = 4'h6;
      SEG_7:     o_nib = 4'h7;
      SEG_8:     o_nib = 4'h8;
      SEG_9:     o_nib = 4'h9;
      SEG_BLANK: o_nib = NIB_BLANK;
      default: begin
        o_nib = NIB_BAD;
        o_bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Scan-bus receiver: waits for the multiplexed {enb,seg,dp} bus to settle,
// captures one digit per stable dwell and reassembles the six-digit frame.
module fnd_scan_rx
  import fnd_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           i_seg,
  input  logic                 i_seg_dp,
  input  logic [N_DIG-1:0]     i_seg_enb,
  output logic [7*N_DIG-1:0]   o_six_digit_seg,
  output logic [N_DIG-1:0]     o_six_dp,
  output logic [4*N_DIG-1:0]   o_digits,
  output logic                 o_frame_vld,
  output logic                 o_err_enb,
  output logic                 o_err_pat
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  smp_t              r_smp;
  smp_t              r_smp_q;
  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_next;
  logic              w_eq;
  logic              w_eval;

  logic [N_DIG-1:0]  w_zeros;
  logic              w_one_cold;
  logic              w_multi;
  logic [N_DIG-1:0]  w_cap_en;
  logic              w_cap_any;
  logic [N_DIG-1:0]  r_seen;
  logic [N_DIG-1:0]  w_seen_upd;
  logic              w_frame;

  logic [3:0]        w_nib;
  logic              w_bad;

  logic [7*N_DIG-1:0] r_seg;
  logic [N_DIG-1:0]   r_dp;
  logic [4*N_DIG-1:0] r_digits;
  logic               r_frame_vld;
  logic               r_err_enb;
  logic               r_err_pat;

  // Stability tracking: one evaluation per dwell, S_HELD blocks repeats.
  always_comb begin
    w_eq         = (r_smp == r_smp_q);
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    w_eval       = 1'b0;
    case (r_state)
      S_WAIT: w_cnt_next = w_eq ? r_cnt + 1'b1 : '0;
      S_HELD: begin
        if (!w_eq) begin
          w_cnt_next   = '0;
          w_state_next = S_WAIT;
        end
      end
      default: w_state_next = S_WAIT;
    endcase
    if (w_state_next == S_WAIT && w_cnt_next == CW'(STABLE_CNT - 1)) begin
      w_eval       = 1'b1;
      w_state_next = S_HELD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_zeros    = ~r_smp.enb;
  assign w_one_cold = $onehot(w_zeros);
  assign w_multi    = (|w_zeros) && !w_one_cold;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_cap
      assign w_cap_en[gi] = w_eval && w_one_cold && w_zeros[gi];
    end
  endgenerate

  assign w_cap_any  = |w_cap_en;
  assign w_seen_upd = r_seen | w_cap_en;
  assign w_frame    = w_cap_any && (&w_seen_upd);

  fnd_seg_dec u_dec (
    .i_glyph (r_smp.seg),
    .o_nib   (w_nib),
    .o_bad   (w_bad)
  );

  // Sample registers reset to an idle bus so reset itself never looks like a multi-enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp       <= SMP_IDLE;
      r_smp_q     <= SMP_IDLE;
      r_seen      <= '0;
      r_seg       <= '0;
      r_dp        <= '0;
      r_digits    <= '0;
      r_frame_vld <= 1'b0;
      r_err_enb   <= 1'b0;
      r_err_pat   <= 1'b0;
    end else begin
      r_smp       <= '{enb: i_seg_enb, seg: i_seg, dp: i_seg_dp};
      r_smp_q     <= r_smp;
      r_frame_vld <= w_frame;
      r_err_enb   <= w_eval && w_multi;
      r_err_pat   <= w_cap_any && w_bad;
      r_seen      <= w_frame ? '0 : w_seen_upd;
      for (int k = 0; k < N_DIG; k++) begin
        if (w_cap_en[k]) begin
          r_seg[7*k +: 7]    <= r_smp.seg;
          r_dp[k]            <= r_smp.dp;
          r_digits[4*k +: 4] <= w_nib;
        end
      end
    end
  end

  assign o_six_digit_seg = r_seg;
  assign o_six_dp        = r_dp;
  assign o_digits        = r_digits;
  assign o_frame_vld     = r_frame_vld;
  assign o_err_enb       = r_err_enb;
  assign o_err_pat       = r_err_pat;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Bench for fnd_scan_rx: dwell-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fnd_scan_rx;

  localparam int STABLE_CNT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  i_seg = 7'h0;
  logic        i_seg_dp = 1'b0;
  logic [5:0]  i_seg_enb = 6'h3F;
  logic [41:0] o_six_digit_seg;
  logic [5:0]  o_six_dp;
  logic [23:0] o_digits;
  logic        o_frame_vld;
  logic        o_err_enb;
  logic        o_err_pat;

  fnd_scan_rx #(.STABLE_CNT(STABLE_CNT)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_seg           (i_seg),
    .i_seg_dp        (i_seg_dp),
    .i_seg_enb       (i_seg_enb),
    .o_six_digit_seg (o_six_digit_seg),
    .o_six_dp        (o_six_dp),
    .o_digits        (o_digits),
    .o_frame_vld     (o_frame_vld),
    .o_err_enb       (o_err_enb),
    .o_err_pat       (o_err_pat)
  );

  always #10 clk = ~clk;

  logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  int n_chk  = 0;
  int n_pass = 0;
  int n_fv   = 0;
  int n_ee   = 0;
  int n_ep   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [41:0] m_seg;
  logic [5:0]  m_dp;
  logic [23:0] m_dig;
  logic [5:0]  m_seen;
  logic        m_fv, m_ee, m_ep;
  logic        pend;
  logic [13:0] pend_val;
  logic [13:0] prev;
  int          run;

  function automatic logic [4:0] m_decode(input logic [6:0] g);
    for (int i = 0; i < 10; i++) if (g == glyph[i]) return {1'b0, 4'(i)};
    if (g == 7'd0) return {1'b0, 4'hA};
    return {1'b1, 4'hF};
  endfunction

  task automatic m_apply(input logic [13:0] v);
    logic [5:0] enb;
    logic [4:0] d;
    int zeros;
    int k;
    enb = v[13:8];
    zeros = 0;
    k = 0;
    for (int i = 0; i < 6; i++) if (!enb[i]) begin zeros++; k = i; end
    if (zeros > 1) m_ee = 1'b1;
    else if (zeros == 1) begin
      d = m_decode(v[7:1]);
      m_seg[7*k +: 7] = v[7:1];
      m_dp[k]         = v[0];
      m_dig[4*k +: 4] = d[3:0];
      m_ep            = d[4];
      m_seen[k]       = 1'b1;
      if (m_seen == 6'h3F) begin
        m_fv   = 1'b1;
        m_seen = 6'h0;
      end
    end
  endtask

  // A value present on STABLE_CNT consecutive edges is reflected one edge later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_seg = 0; m_dp = 0; m_dig = 0; m_seen = 0;
      m_fv = 0; m_ee = 0; m_ep = 0; pend = 0; pend_val = 0;
      prev = {6'h3F, 7'h0, 1'b0};
      run  = STABLE_CNT + 1;
    end else begin
      m_fv = 0; m_ee = 0; m_ep = 0;
      if (pend) m_apply(pend_val);
      pend = 0;
      if ({i_seg_enb, i_seg, i_seg_dp} == prev) begin
        if (run <= STABLE_CNT) run++;
      end else run = 1;
      prev = {i_seg_enb, i_seg, i_seg_dp};
      if (run == STABLE_CNT) begin
        pend = 1'b1;
        pend_val = prev;
      end
    end
  end

  // Per-cycle comparison, sampled mid-cycle.
  always begin
    @(posedge clk);
    #5;
    if (!rst) begin
      chk("seg",   64'(o_six_digit_seg), 64'(m_seg));
      chk("dp",    64'(o_six_dp),        64'(m_dp));
      chk("dig",   64'(o_digits),        64'(m_dig));
      chk("fvld",  64'(o_frame_vld),     64'(m_fv));
      chk("errenb",64'(o_err_enb),       64'(m_ee));
      chk("errpat",64'(o_err_pat),       64'(m_ep));
      if (o_frame_vld) n_fv++;
      if (o_err_enb)   n_ee++;
      if (o_err_pat)   n_ep++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
    i_seg_enb = enb;
    i_seg     = seg;
    i_seg_dp  = dp;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    i_seg_enb = 6'h3F; i_seg = 7'h0; i_seg_dp = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [5:0] sel(input int k);
    return ~(6'b1 << k);
  endfunction

  int fv0, ee0, ep0;

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_dig", 64'(o_digits), 64'h0);
    chk("rst_seg", 64'(o_six_digit_seg), 64'h0);
    chk("rst_pulses", 64'({o_frame_vld, o_err_enb, o_err_pat}), 64'h0);

    // 1: "3","7" then blanks
    fv0 = n_fv; ee0 = n_ee; ep0 = n_ep;
    drive(sel(0), glyph[3], 1'b0, 8);
    drive(sel(1), glyph[7], 1'b0, 8);
    for (int k = 2; k < 6; k++) drive(sel(k), 7'h0, 1'b0, 8);
    drive(6'h3F, 7'h0, 1'b0, 4);
    chk("t1_digits", 64'(o_digits), 64'hAAAA73);
    chk("t1_frames", 64'(n_fv - fv0), 64'd1);
    chk("t1_errs", 64'((n_ee - ee0) + (n_ep - ep0)), 64'd0);

    // 2: short dwell ignored, full dwell captured on edge STABLE_CNT+1
    do_reset();
    drive(6'b111110, glyph[5], 1'b0, 3);
    drive(6'h3F, 7'h0, 1'b0, 4);
    chk("t2_short", 64'(o_digits), 64'h0);
    drive(6'b111110, glyph[5], 1'b0, 4);
    chk("t2_edge4", 64'(o_digits[3:0]), 64'h0);
    @(negedge clk);
    chk("t2_edge5", 64'(o_digits[3:0]), 64'h5);
    repeat (3) @(negedge clk);

    // 3: two enables low
    do_reset();
    ee0 = n_ee;
    drive(6'b111100, glyph[8], 1'b0, 10);
    drive(6'h3F, 7'h0, 1'b0, 4);
    chk("t3_errenb", 64'(n_ee - ee0), 64'd1);
    chk("t3_dig", 64'(o_digits), 64'h0);
    chk("t3_seg", 64'(o_six_digit_seg), 64'h0);

    // 4: unknown glyph on digit 2
    do_reset();
    ep0 = n_ep;
    drive(sel(2), 7'b0000001, 1'b1, 8);
    drive(6'h3F, 7'h0, 1'b0, 4);
    chk("t4_nib", 64'(o_digits[11:8]), 64'hF);
    chk("t4_seg", 64'(o_six_digit_seg[20:14]), 64'h1);
    chk("t4_dp", 64'(o_six_dp), 64'h4);
    chk("t4_errpat", 64'(n_ep - ep0), 64'd1);

    // 5: reset mid-frame discards partial frame
    do_reset();
    fv0 = n_fv;
    for (int k = 0; k < 4; k++) drive(sel(k), glyph[k], 1'b0, 8);
    do_reset();
    for (int k = 4; k < 6; k++) drive(sel(k), glyph[k], 1'b0, 8);
    drive(6'h3F, 7'h0, 1'b0, 4);
    chk("t5_nofrm", 64'(n_fv - fv0), 64'd0);
    for (int k = 0; k < 6; k++) drive(sel(k), glyph[k], 1'b0, 8);
    chk("t5_frm", 64'(n_fv - fv0), 64'd1);
    chk("t5_dig", 64'(o_digits), 64'h543210);

    // 6: seconds counter 00..59 over 120 frames
    do_reset();
    ee0 = n_ee; ep0 = n_ep;
    for (int f = 0; f < 120; f++) begin
      int v;
      v = f % 60;
      fv0 = n_fv;
      drive(sel(0), glyph[v % 10], 1'b0, 8);
      drive(sel(1), glyph[v / 10], 1'b0, 8);
      for (int k = 2; k < 6; k++) drive(sel(k), 7'h0, 1'b0, 8);
      if (f % 20 == 0 || n_fv - fv0 != 1 || o_digits != {16'hAAAA, 4'(v / 10), 4'(v % 10)}) begin
        chk("t6_frame", 64'(n_fv - fv0), 64'd1);
        chk("t6_dig", 64'(o_digits), 64'({16'hAAAA, 4'(v / 10), 4'(v % 10)}));
        chk("t6_dp", 64'(o_six_dp), 64'h0);
      end
    end
    chk("t6_errs", 64'((n_ee - ee0) + (n_ep - ep0)), 64'd0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
